delta_factory_mc: RTL and testbench

Parametrised multi-channel successor to the single-channel delta-trigger test generator. It has NCH independent channels that share one gap, trigger-count and pattern configuration. Each channel emits a programmable PAT_LEN-bit header pattern, then waits a programmable gap, and repeats until the requested number of bursts is reached. It sits in the Top CDT test-trigger path, feeding the trigger mux, and adds per-channel status and burst-count readback.

---
 rtl/delta_factory_mc.sv | 146 ++++++++++++++
 tb/tb_delta_factory_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_factory_mc.sv
// Multi-channel delta-trigger pattern generator: NCH channels that share gap, burst-count and pattern settings.
// Optional build macro DELTA_FACTORY_MC_SKIP_FIRST_EN blanks the trig output of every burst started with trig_cnt = 0.
module delta_factory_mc #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned GAP_W   = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PAT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_live,
    input  logic [NCH-1:0]       in_ena,
    input  logic [GAP_W-1:0]     user_gap,
    input  logic [CNT_W-1:0]     user_ntrig,
    input  logic [PAT_LEN-1:0]   user_pattern,
    output logic [NCH-1:0]       trig,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH*CNT_W-1:0] trig_cnt
);

    localparam int unsigned IDX_W = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {StIdle, StGap, StBurst, StDone} state_e;

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [GAP_W-1:0] gap_q   [NCH];
    logic [GAP_W-1:0] gap_d   [NCH];
    logic [IDX_W-1:0] idx_q   [NCH];
    logic [IDX_W-1:0] idx_d   [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];

    logic [NCH-1:0] trig_q, trig_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] emit;
    logic           ntrig_inf;

    assign ntrig_inf = &user_ntrig;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
`ifdef DELTA_FACTORY_MC_SKIP_FIRST_EN
            emit[k] = (cnt_q[k] != '0);
`else
            emit[k] = 1'b1;
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            gap_d[k]   = gap_q[k];
            idx_d[k]   = idx_q[k];
            cnt_d[k]   = cnt_q[k];
            trig_d[k]  = 1'b0;

            unique case (state_q[k])
                StIdle: begin
                    if (in_ena[k]) begin
                        if (user_ntrig == '0) begin
                            state_d[k] = StDone;
                        end else begin
                            state_d[k] = StGap;
                            gap_d[k]   = '0;
                        end
                    end
                end
                StGap: begin
                    if (in_ena[k]) begin
                        if (gap_q[k] < user_gap) begin
                            gap_d[k] = gap_q[k] + 1'b1;
                        end else begin
                            state_d[k] = StBurst;
                            idx_d[k]   = IDX_W'(1);
                            trig_d[k]  = user_pattern[0] & emit[k];
                        end
                    end
                end
                StBurst: begin
                    // Disabled edges fall through: state held, trig forced low.
                    if (in_ena[k]) begin
                        trig_d[k] = user_pattern[idx_q[k]] & emit[k];
                        idx_d[k]  = idx_q[k] + 1'b1;
                        if (idx_q[k] == IDX_LAST) begin
                            cnt_d[k] = cnt_q[k] + 1'b1;
                            gap_d[k] = '0;
                            idx_d[k] = '0;
                            if (!ntrig_inf && (cnt_q[k] + 1'b1 == user_ntrig)) begin
                                state_d[k] = StDone;
                            end else begin
                                state_d[k] = StGap;
                            end
                        end
                    end
                end
                StDone: begin
                end
                default: state_d[k] = StIdle;
            endcase

            busy_d[k] = (state_d[k] == StGap) || (state_d[k] == StBurst);
            done_d[k] = (state_d[k] == StDone);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !in_live) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= StIdle;
                gap_q[k]   <= '0;
                idx_q[k]   <= '0;
                cnt_q[k]   <= '0;
            end
            trig_q <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                gap_q[k]   <= gap_d[k];
                idx_q[k]   <= idx_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            trig_q <= trig_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign trig = trig_q;
    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        trig_cnt = '0;
        for (int k = 0; k < NCH; k++) begin
            trig_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

endmodule

// File: tb/tb_delta_factory_mc.sv
// Randomized bench for delta_factory_mc: two instances (CNT_W=16 and CNT_W=4) checked against an arithmetic schedule model.
module tb_delta_factory_mc;

    localparam int PAT = 4;

    logic        clk = 1'b0;
    logic        rst, live;
    logic [3:0]  ena;
    logic [31:0] gap;
    logic [15:0] ntrig16;
    logic [3:0]  ntrig4;
    logic [3:0]  pat;

    logic [3:0]  a_trig, a_busy, a_done;
    logic [63:0] a_cnt;
    logic [3:0]  b_trig, b_busy, b_done;
    logic [15:0] b_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Enabled-edge count per channel since the last clear; the whole schedule derives from it.
    longint ev_m [2][4];
    bit     mt   [2][4];

    always #5 clk = ~clk;

    delta_factory_mc #(.NCH(4), .GAP_W(32), .CNT_W(16), .PAT_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .in_live(live), .in_ena(ena), .user_gap(gap),
        .user_ntrig(ntrig16), .user_pattern(pat), .trig(a_trig), .busy(a_busy),
        .done(a_done), .trig_cnt(a_cnt)
    );

    delta_factory_mc #(.NCH(4), .GAP_W(32), .CNT_W(4), .PAT_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .in_live(live), .in_ena(ena), .user_gap(gap),
        .user_ntrig(ntrig4), .user_pattern(pat), .trig(b_trig), .busy(b_busy),
        .done(b_done), .trig_cnt(b_cnt)
    );

    function automatic longint nt_of(int d);
        return (d == 0) ? longint'(ntrig16) : longint'(ntrig4);
    endfunction

    function automatic bit inf_of(int d);
        return (d == 0) ? (&ntrig16) : (&ntrig4);
    endfunction

    function automatic int cw_of(int d);
        return (d == 0) ? 16 : 4;
    endfunction

    // First burst starts on enabled edge g+2, bursts repeat every PAT+g edges.
    function automatic bit m_done(longint ev, int d);
        longint g = longint'(gap);
        if (ev == 0 || inf_of(d)) return 1'b0;
        if (nt_of(d) == 0) return 1'b1;
        return ev >= g + 2 + (nt_of(d) - 1) * (PAT + g) + PAT - 1;
    endfunction

    function automatic bit m_trig(longint ev, int d);
        longint g = longint'(gap);
        longint m, per, r;
        if (ev < g + 2) return 1'b0;
        m   = ev - g - 2;
        per = PAT + g;
        r   = m % per;
        if (r >= PAT) return 1'b0;
`ifdef DELTA_FACTORY_MC_SKIP_FIRST_EN
        if (((m / per) % (longint'(1) << cw_of(d))) == 0) return 1'b0;
`endif
        return pat[int'(r)];
    endfunction

    function automatic longint m_cnt(longint ev, int d);
        longint g = longint'(gap);
        longint m;
        if (ev < g + 2 + PAT - 1) return 0;
        m = ev - g - 2;
        return ((m - (PAT - 1)) / (PAT + g) + 1) % (longint'(1) << cw_of(d));
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (rst || !live) begin
                    ev_m[d][k] <= 0;
                    mt[d][k]   <= 1'b0;
                end else if (ev_m[d][k] == 0) begin
                    mt[d][k] <= 1'b0;
                    if (ena[k]) ev_m[d][k] <= 1;
                end else if (m_done(ev_m[d][k], d)) begin
                    mt[d][k] <= 1'b0;
                end else if (ena[k]) begin
                    ev_m[d][k] <= ev_m[d][k] + 1;
                    mt[d][k]   <= m_trig(ev_m[d][k] + 1, d);
                end else begin
                    mt[d][k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                automatic logic [3:0]  et, eb, ed, at, ab, ad;
                automatic logic [63:0] ec, ac;
                for (int k = 0; k < 4; k++) begin
                    et[k] = mt[d][k];
                    ed[k] = m_done(ev_m[d][k], d);
                    eb[k] = (ev_m[d][k] != 0) && !ed[k];
                    ec[k*16 +: 16] = 16'(m_cnt(ev_m[d][k], d));
                    ac[k*16 +: 16] = (d == 0) ? a_cnt[k*16 +: 16] : {12'b0, b_cnt[k*4 +: 4]};
                end
                at = (d == 0) ? a_trig : b_trig;
                ab = (d == 0) ? a_busy : b_busy;
                ad = (d == 0) ? a_done : b_done;
                tests++;
                if ({at, ab, ad, ac} !== {et, eb, ed, ec}) begin
                    fails++;
                    $display("FAIL model_dut%0d t=%0t: got trig=%b busy=%b done=%b cnt=%h, need trig=%b busy=%b done=%b cnt=%h",
                             d, $time, at, ab, ad, ac, et, eb, ed, ec);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %0h, need %0h", name, $time, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_all();
        live = 1'b0;
        tick();
    endtask

    initial begin
        bit     wrap_seen, any_done, e;
        logic [3:0] prev;

        rst = 1'b1; live = 1'b0; ena = '0; gap = '0;
        ntrig16 = '0; ntrig4 = '0; pat = '0;
        tick();
        tick();
        chk_on = 1'b1;
        chk("reset_trig", 64'(a_trig), 64'h0);
        chk("reset_busy", 64'(a_busy), 64'h0);
        chk("reset_done", 64'(a_done), 64'h0);
        chk("reset_cnt", a_cnt, 64'h0);

        // Pattern 1001, gap 3, three bursts on channel 0.
        rst = 1'b0; live = 1'b1; gap = 32'd3; pat = 4'b1001;
        ntrig16 = 16'd3; ntrig4 = 4'd3; ena = 4'b0001;
        for (int c = 1; c <= 25; c++) begin
            tick();
            case (c)
`ifdef DELTA_FACTORY_MC_SKIP_FIRST_EN
                12, 15, 19, 22: e = 1'b1;
`else
                5, 8, 12, 15, 19, 22: e = 1'b1;
`endif
                default: e = 1'b0;
            endcase
            chk($sformatf("t1_trig0_c%0d", c), 64'(a_trig[0]), 64'(e));
        end
        chk("t1_cnt0", 64'(a_cnt[15:0]), 64'd3);
        chk("t1_done0", 64'(a_done[0]), 64'd1);
        chk("t1_idle_busy", 64'(a_busy[3:1]), 64'd0);
        chk("t1_idle_cnt", a_cnt[63:16], 64'd0);
        chk("t1_b_cnt0", 64'(b_cnt[3:0]), 64'd3);
        clear_all();

        // Zero bursts requested: straight to DONE.
        ntrig16 = '0; ntrig4 = '0; ena = 4'b1111; live = 1'b1;
        tick();
        chk("nt0_done_a", 64'(a_done), 64'hf);
        chk("nt0_done_b", 64'(b_done), 64'hf);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("nt0_trig", 64'(a_trig), 64'h0);
        end
        clear_all();

        // Infinite mode on the narrow counter: wraps 15 -> 0, never done.
        gap = '0; pat = 4'b0011; ntrig16 = 16'hffff; ntrig4 = 4'hf; ena = 4'b0001;
        live = 1'b1; wrap_seen = 1'b0; any_done = 1'b0; prev = '0;
        for (int c = 1; c <= 72; c++) begin
            tick();
            if (c >= 6 && c <= 13)
                chk($sformatf("inf_trig0_c%0d", c), 64'(b_trig[0]), 64'(((c - 2) % 4) < 2));
            if (prev == 4'd15 && b_cnt[3:0] == 4'd0) wrap_seen = 1'b1;
            prev = b_cnt[3:0];
            any_done = any_done | a_done[0] | b_done[0];
        end
        chk("inf_wrap", 64'(wrap_seen), 64'd1);
        chk("inf_no_done", 64'(any_done), 64'd0);
        chk("inf_cnt_a", 64'(a_cnt[15:0]), 64'd17);
        chk("inf_cnt_b", 64'(b_cnt[3:0]), 64'd1);
        clear_all();

        // Pause channel 1 for two edges right after pattern bit 1, then reset mid-burst.
        gap = 32'd2; pat = 4'b1011; ntrig16 = 16'd2; ntrig4 = 4'd2; ena = 4'b0010;
        live = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
`ifdef DELTA_FACTORY_MC_SKIP_FIRST_EN
        chk("pause_bit1", 64'(a_trig[1]), 64'd0);
`else
        chk("pause_bit1", 64'(a_trig[1]), 64'd1);
`endif
        ena = 4'b0000;
        tick();
        chk("pause_hold_a", 64'(a_trig[1]), 64'd0);
        tick();
        chk("pause_hold_b", 64'(a_trig[1]), 64'd0);
        chk("pause_busy", 64'(a_busy[1]), 64'd1);
        ena = 4'b0010;
        tick();
        chk("pause_bit2", 64'(a_trig[1]), 64'd0);
        tick();
`ifdef DELTA_FACTORY_MC_SKIP_FIRST_EN
        chk("pause_bit3", 64'(a_trig[1]), 64'd0);
`else
        chk("pause_bit3", 64'(a_trig[1]), 64'd1);
`endif
        chk("pause_cnt", 64'(a_cnt[31:16]), 64'd1);
        tick(); tick(); tick();
        chk("burst2_bit0", 64'(a_trig[1]), 64'd1);
        rst = 1'b1;
        tick();
        chk("rst_trig", 64'(a_trig), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_cnt", a_cnt, 64'd0);
        rst = 1'b0;
        clear_all();

        // Drop in_live in a gap after one completed burst.
        gap = 32'd5; pat = 4'b0110; ntrig16 = 16'hffff; ntrig4 = 4'hf; ena = 4'b1111;
        live = 1'b1;
        for (int c = 1; c <= 12; c++) tick();
        chk("live_pre_cnt", 64'(a_cnt[15:0]), 64'd1);
        chk("live_pre_busy", 64'(a_busy), 64'hf);
        live = 1'b0;
        tick();
        chk("live_cnt_a", a_cnt, 64'd0);
        chk("live_busy", 64'(a_busy), 64'd0);
        chk("live_cnt_b", 64'(b_cnt), 64'd0);

        // Random sessions; config only changes after a clearing edge.
        for (int s = 0; s < 30; s++) begin
            automatic int sel = $urandom_range(0, 6);
            automatic int len = $urandom_range(30, 150);
            gap = 32'($urandom_range(0, 4));
            pat = 4'($urandom);
            if (sel == 6) begin
                ntrig16 = 16'hffff; ntrig4 = 4'hf;
            end else begin
                ntrig16 = 16'(sel); ntrig4 = 4'(sel);
            end
            for (int i = 0; i < len; i++) begin
                for (int k = 0; k < 4; k++) ena[k] = ($urandom_range(0, 7) != 0);
                rst  = ($urandom_range(0, 99) == 0);
                live = ($urandom_range(0, 79) != 0);
                tick();
            end
            rst = 1'b0;
            clear_all();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
